// File: rtl/noc_local_inject_arbiter_if.sv
// Local-injection handshake bundle: per-source flit inputs, the single router-facing flit output and status.
// master = sources/router/observer side, slave = arbiter side.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

interface noc_local_inject_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = `Noc_Data_Width,
  parameter int CNT_W   = 16,
  parameter int GNT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ-1:0]        in_ready;
  logic [NUM_REQ*DATA_W-1:0] in_flit;
  logic [NUM_REQ-1:0]        in_is_header;
  logic [NUM_REQ-1:0]        in_is_tail;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_flit;
  logic                      out_is_header;
  logic                      out_is_tail;
  logic [GNT_W-1:0]          grant_id;
  logic                      busy;
  logic [CNT_W-1:0]          pkt_cnt;
  logic                      err_sticky;

  modport slave (
    input  in_valid, in_flit, in_is_header, in_is_tail, out_ready,
    output in_ready, out_valid, out_flit, out_is_header, out_is_tail,
           grant_id, busy, pkt_cnt, err_sticky
  );

  modport master (
    output in_valid, in_flit, in_is_header, in_is_tail, out_ready,
    input  in_ready, out_valid, out_flit, out_is_header, out_is_tail,
           grant_id, busy, pkt_cnt, err_sticky
  );
endinterface

// File: rtl/noc_local_inject_arbiter.sv
// Packet-level round-robin share of one router injection port; 1-cycle registered flit path, 1 idle arbitration cycle per packet.
// Backpressure: the owner's in_ready follows the output stage (free or draining); a held output flit is never dropped.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_local_inject_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = `Noc_Data_Width,
  parameter int CNT_W   = 16
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst,
  noc_local_inject_arbiter_if.slave  bus
);

  localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e              state_q, state_d;
  logic [GNT_W-1:0]    grant_q, grant_d;
  logic                first_q, first_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_flit_q, out_flit_d;
  logic                out_hdr_q, out_hdr_d;
  logic                out_tail_q, out_tail_d;
  logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  drain;
  logic [NUM_REQ-1:0]  in_ready;
  logic [GNT_W-1:0]    pick;
  logic                pick_vld;
  logic                stage_free;
  logic                out_fire;
  logic                sel_valid;
  logic                sel_hdr;
  logic                sel_tail;
  logic [DATA_W-1:0]   sel_flit;

  assign eligible   = bus.in_valid & bus.in_is_header;
  assign drain      = bus.in_valid & ~bus.in_is_header;
  assign stage_free = !out_valid_q || bus.out_ready;
  assign out_fire   = out_valid_q && bus.out_ready;

  assign sel_valid = bus.in_valid[grant_q];
  assign sel_hdr   = bus.in_is_header[grant_q];
  assign sel_tail  = bus.in_is_tail[grant_q];
  assign sel_flit  = bus.in_flit[int'(grant_q)*DATA_W +: DATA_W];

  // Round-robin search starts one past the last owner.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick     = grant_q;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(grant_q) + k) % NUM_REQ;
      if (!pick_vld && eligible[idx[GNT_W-1:0]]) begin
        pick     = idx[GNT_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    first_d     = first_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    out_hdr_d   = out_hdr_q;
    out_tail_d  = out_tail_q;
    pkt_cnt_d   = pkt_cnt_q;
    in_ready    = '0;

    if (out_fire) begin
      out_valid_d = 1'b0;
      if (out_tail_q) pkt_cnt_d = pkt_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        // Headerless flits arriving outside a packet are swallowed and flagged.
        in_ready = drain;
        if (|drain) err_d = 1'b1;
        if (pick_vld) begin
          grant_d = pick;
          first_d = 1'b1;
          state_d = LOCK;
        end
      end
      LOCK: begin
        in_ready[grant_q] = stage_free;
        if (sel_valid && stage_free) begin
          out_valid_d = 1'b1;
          out_flit_d  = sel_flit;
          out_hdr_d   = sel_hdr;
          out_tail_d  = sel_tail;
          first_d     = 1'b0;
          if (sel_hdr && !first_q) err_d = 1'b1;
          if (sel_tail) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_q     <= IDLE;
      grant_q     <= GNT_W'(NUM_REQ - 1);
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_hdr_q   <= 1'b0;
      out_tail_q  <= 1'b0;
      pkt_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_hdr_q   <= out_hdr_d;
      out_tail_q  <= out_tail_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_flit      = out_flit_q;
  assign bus.out_is_header = out_hdr_q;
  assign bus.out_is_tail   = out_tail_q;
  assign bus.grant_id      = grant_q;
  assign bus.busy          = (state_q == LOCK);
  assign bus.pkt_cnt       = pkt_cnt_q;
  assign bus.err_sticky    = err_q;

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Directed bench for noc_local_inject_arbiter: packet-level model checked every cycle plus literal scenario expectations.
module tb_noc_local_inject_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct packed { logic [DW-1:0] dat; logic hdr; logic tl; } flit_t;
  typedef struct packed { logic [31:0] cyc; logic [DW-1:0] dat; logic hdr; logic tl; } xfer_t;

  logic noc_clk = 1'b0;
  logic noc_rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  flit_t srcq [N][$];
  xfer_t out_log [$];

  noc_local_inject_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) bus ();

  noc_local_inject_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .noc_clk (noc_clk),
    .noc_rst (noc_rst),
    .bus     (bus)
  );

  always #5 noc_clk = ~noc_clk;
  always @(posedge noc_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fl(input int src, input int pkt, input int idx);
    return {4'(src), 12'(pkt), 16'(idx)};
  endfunction

  task automatic push_pkt(input int src, input int pkt, input int len);
    for (int i = 0; i < len; i++)
      srcq[src].push_back('{dat: fl(src, pkt, i), hdr: (i == 0), tl: (i == len - 1)});
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        bus.in_valid[i]           = 1'b1;
        bus.in_flit[i*DW +: DW]   = srcq[i][0].dat;
        bus.in_is_header[i]       = srcq[i][0].hdr;
        bus.in_is_tail[i]         = srcq[i][0].tl;
      end else begin
        bus.in_valid[i]           = 1'b0;
        bus.in_flit[i*DW +: DW]   = '0;
        bus.in_is_header[i]       = 1'b0;
        bus.in_is_tail[i]         = 1'b0;
      end
    end
  endtask

  // One cycle: sources pop whatever was handshaken, then present their next flit.
  task automatic tick();
    logic [N-1:0] hs;
    flit_t        dummy;
    @(negedge noc_clk);
    hs = bus.in_valid & bus.in_ready;
    @(posedge noc_clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i] && srcq[i].size() > 0) dummy = srcq[i].pop_front();
    drive();
  endtask

  task automatic wait_log(input int n, input int budget);
    int k;
    k = 0;
    while (out_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_log_timeout", 64'(out_log.size() >= n), 64'd1);
  endtask

  // Behavioural model: who owns the port, the held output flit and the counters.
  int               m_owner;
  int               m_last;
  bit               m_first;
  bit               m_ov, m_oh, m_ot, m_err;
  logic [DW-1:0]    m_of;
  logic [CW-1:0]    m_cnt;
  logic [N-1:0]     m_rdy;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_first = 0;
    m_ov = 0; m_oh = 0; m_ot = 0; m_of = '0; m_cnt = '0; m_err = 0;
  endtask

  task automatic model_step();
    int o;
    if (m_ov && bus.out_ready) begin
      if (m_ot) m_cnt = m_cnt + 1'b1;
      m_ov = 0;
    end
    if (m_owner < 0) begin
      if ((bus.in_valid & ~bus.in_is_header) != '0) m_err = 1;
      for (int k = 1; k <= N; k++) begin
        o = (m_last + k) % N;
        if (m_owner < 0 && bus.in_valid[o] && bus.in_is_header[o]) begin
          m_owner = o; m_last = o; m_first = 1;
        end
      end
    end else begin
      o = m_owner;
      if (bus.in_valid[o] && m_rdy[o]) begin
        m_ov = 1;
        m_of = bus.in_flit[o*DW +: DW];
        m_oh = bus.in_is_header[o];
        m_ot = bus.in_is_tail[o];
        if (m_oh && !m_first) m_err = 1;
        m_first = 0;
        if (m_ot) m_owner = -1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge noc_clk);
      if (noc_rst) model_reset();
      m_rdy = '0;
      if (m_owner < 0) m_rdy = bus.in_valid & ~bus.in_is_header;
      else if (!m_ov || bus.out_ready) m_rdy[m_owner] = 1'b1;
      check("m_in_ready",  64'(bus.in_ready),      64'(m_rdy));
      check("m_out_valid", 64'(bus.out_valid),     64'(m_ov));
      check("m_out_flit",  64'(bus.out_flit),      64'(m_of));
      check("m_out_hdr",   64'(bus.out_is_header), 64'(m_oh));
      check("m_out_tail",  64'(bus.out_is_tail),   64'(m_ot));
      check("m_grant_id",  64'(bus.grant_id),      64'(m_last));
      check("m_busy",      64'(bus.busy),          64'(m_owner >= 0));
      check("m_pkt_cnt",   64'(bus.pkt_cnt),       64'(m_cnt));
      check("m_err",       64'(bus.err_sticky),    64'(m_err));
      if (bus.out_valid && bus.out_ready)
        out_log.push_back('{cyc: 32'(cyc), dat: bus.out_flit, hdr: bus.out_is_header, tl: bus.out_is_tail});
      @(posedge noc_clk);
      if (noc_rst) model_reset();
      else model_step();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0, rel;
    int exp_src [5];
    int exp_pkt [5];

    noc_rst = 1'b1;
    bus.out_ready = 1'b1;
    drive();
    repeat (3) @(posedge noc_clk);
    #1;
    check("rst_grant",     64'(bus.grant_id),   64'd3);
    check("rst_out_valid", 64'(bus.out_valid),  64'd0);
    check("rst_busy",      64'(bus.busy),       64'd0);
    check("rst_pkt_cnt",   64'(bus.pkt_cnt),    64'd0);
    check("rst_err",       64'(bus.err_sticky), 64'd0);
    noc_rst = 1'b0;
    tick(); tick();

    // Single source, header + 10 data + tail.
    base = out_log.size();
    push_pkt(0, 1, 12);
    drive();
    c0 = cyc;
    wait_log(base + 12, 60);
    check("t1_hdr_latency", 64'(out_log[base].cyc), 64'(c0 + 2));
    for (int i = 0; i < 12; i++) begin
      check("t1_flit",   64'(out_log[base+i].dat), 64'(fl(0, 1, i)));
      check("t1_consec", 64'(out_log[base+i].cyc), 64'(c0 + 2 + i));
    end
    tick(); tick();
    check("t1_pkt_cnt", 64'(bus.pkt_cnt), 64'd1);
    check("t1_busy",    64'(bus.busy),    64'd0);

    // Four sources from reset, source 0 with a second packet queued.
    noc_rst = 1'b1;
    tick(); tick();
    noc_rst = 1'b0;
    base = out_log.size();
    push_pkt(0, 2, 3); push_pkt(1, 2, 3); push_pkt(2, 2, 3); push_pkt(3, 2, 3); push_pkt(0, 3, 3);
    drive();
    wait_log(base + 15, 80);
    exp_src = '{0, 1, 2, 3, 0};
    exp_pkt = '{2, 2, 2, 2, 3};
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 3; i++)
        check("t2_order", 64'(out_log[base + 3*p + i].dat), 64'(fl(exp_src[p], exp_pkt[p], i)));
    tick(); tick();
    check("t2_pkt_cnt", 64'(bus.pkt_cnt), 64'd5);

    // Backpressure for 5 cycles with the 4th flit held.
    base = out_log.size();
    push_pkt(2, 4, 8);
    drive();
    wait_log(base + 3, 30);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_flit", 64'(bus.out_flit),    64'(fl(2, 4, 3)));
      check("t3_hold_vld",  64'(bus.out_valid),   64'd1);
      check("t3_rdy_low",   64'(bus.in_ready[2]), 64'd0);
    end
    bus.out_ready = 1'b1;
    rel = cyc;
    wait_log(base + 8, 30);
    for (int i = 0; i < 8; i++)
      check("t3_flit", 64'(out_log[base+i].dat), 64'(fl(2, 4, i)));
    for (int j = 0; j < 5; j++)
      check("t3_resume", 64'(out_log[base+3+j].cyc), 64'(rel + j));

    // Single-flit packets from sources 1 and 2.
    base = out_log.size();
    push_pkt(1, 5, 1); push_pkt(2, 5, 1);
    drive();
    wait_log(base + 2, 20);
    check("t4_first",  64'(out_log[base].dat),   64'(fl(1, 5, 0)));
    check("t4_second", 64'(out_log[base+1].dat), 64'(fl(2, 5, 0)));
    check("t4_flags",  64'({out_log[base].hdr, out_log[base].tl}), 64'd3);
    check("t4_spacing", 64'(out_log[base+1].cyc - out_log[base].cyc), 64'd2);
    tick(); tick();
    check("t4_pkt_cnt", 64'(bus.pkt_cnt), 64'd8);

    // Headerless flit in IDLE on source 3.
    check("t5_err_before", 64'(bus.err_sticky), 64'd0);
    base = out_log.size();
    srcq[3].push_back('{dat: fl(3, 6, 1), hdr: 1'b0, tl: 1'b0});
    drive();
    #1;
    check("t5_drain_rdy", 64'(bus.in_ready), 64'h8);
    tick(); tick(); tick();
    check("t5_err_after", 64'(bus.err_sticky), 64'd1);
    check("t5_no_out",    64'(out_log.size()), 64'(base));
    check("t5_srcq_empty", 64'(srcq[3].size()), 64'd0);

    // Reset during the 4th flit of a packet.
    push_pkt(1, 7, 6);
    drive();
    wait_log(base + 3, 30);
    noc_rst = 1'b1;
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    #1;
    check("t6_out_valid", 64'(bus.out_valid),     64'd0);
    check("t6_out_flit",  64'(bus.out_flit),      64'd0);
    check("t6_out_flags", 64'({bus.out_is_header, bus.out_is_tail}), 64'd0);
    check("t6_busy",      64'(bus.busy),          64'd0);
    check("t6_grant",     64'(bus.grant_id),      64'd3);
    check("t6_pkt_cnt",   64'(bus.pkt_cnt),       64'd0);
    check("t6_err",       64'(bus.err_sticky),    64'd0);
    tick(); tick();
    noc_rst = 1'b0;
    base = out_log.size();
    push_pkt(2, 8, 4); push_pkt(0, 8, 4);
    drive();
    wait_log(base + 8, 40);
    for (int i = 0; i < 4; i++) begin
      check("t6_src0_pkt", 64'(out_log[base+i].dat),   64'(fl(0, 8, i)));
      check("t6_src2_pkt", 64'(out_log[base+4+i].dat), 64'(fl(2, 8, i)));
    end
    tick(); tick(); tick();
    check("t6_pkt_cnt_end", 64'(bus.pkt_cnt), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
